wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_arbiter_if.sv | 53 +++++
 rtl/wb_fifo2.sv | 59 +++++
 rtl/wb_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: register-address width, source indices, queue-entry struct.
package wb_pkg;

  // Register-file address width.
  localparam int RA_W = 5;

  // Default data width of a write-back value.
  localparam int XLEN_DEF = 32;

  // Source indices, also the encoding of the last-grant bit.
  localparam logic ALU = 1'b0;
  localparam logic MEM = 1'b1;

  // One queued write-back: destination register plus value.
  typedef struct packed {
    logic [RA_W-1:0]     rd;
    logic [XLEN_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the write-back arbiter's source handshakes and register-file side.
// Latency: n/a (wires only).
// Backpressure: alu_ready/mem_ready flow from the arbiter back to each source.
// Ports: alu_*/mem_* valid-ready sources, Wen/Rd/BusW write port,
//        Rs1/Rs2 read addresses with fwd_a/fwd_b hits, idle status.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int XLEN = 32
);

  logic            alu_valid;
  logic            alu_ready;
  logic [RA_W-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            mem_valid;
  logic            mem_ready;
  logic [RA_W-1:0] mem_rd;
  logic [XLEN-1:0] mem_data;

  logic            Wen;
  logic [RA_W-1:0] Rd;
  logic [XLEN-1:0] BusW;

  logic [RA_W-1:0] Rs1;
  logic [RA_W-1:0] Rs2;
  logic            fwd_a;
  logic            fwd_b;

  logic            idle;

  // Sources and register-file read side.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output Rs1, Rs2,
    input  alu_ready, mem_ready,
    input  Wen, Rd, BusW,
    input  fwd_a, fwd_b, idle
  );

  // The arbiter itself.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  Rs1, Rs2,
    output alu_ready, mem_ready,
    output Wen, Rd, BusW,
    output fwd_a, fwd_b, idle
  );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry queue holding pending write-backs for one source.
// Latency: an entry pushed on edge t is visible at head after edge t.
// Backpressure: ready is the registered occupancy < DEPTH; no pass-through when full.
// Ports: clk_n/rst_n; push/push_dat in; pop in; head/empty/ready out.
module wb_fifo2
  import wb_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk_n,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_dat,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   ready
);

  entry_t     mem [DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;   // one bit wider than the pointers: 0..DEPTH

  logic push_ok;
  logic pop_ok;

  assign push_ok = push & ready;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;   // single-bit pointer wraps modulo 2
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign ready = (count < 2'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin merge of ALU and load-unit write-backs onto one register-file port.
// Latency: push at edge t, uncontested, gives Wen=1 in the cycle after edge t+1.
// Backpressure: each source sees its own queue's ready; a full queue stalls its source.
// Ports: clk_n, rst_n (async active-low), bus (wb_arbiter_if.slave).
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk_n,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t alu_in, mem_in, alu_head, mem_head, win;
  logic   alu_push, mem_push, alu_pop, mem_pop;
  logic   alu_empty, mem_empty, alu_rdy, mem_rdy;
  logic   conflict, grant, grant_src, last_grant;

  logic            wen_q;
  logic [RA_W-1:0] rd_q;
  logic [XLEN-1:0] busw_q;

  assign alu_in   = {bus.alu_rd, bus.alu_data};
  assign mem_in   = {bus.mem_rd, bus.mem_data};
  assign alu_push = bus.alu_valid & alu_rdy;
  assign mem_push = bus.mem_valid & mem_rdy;

  wb_fifo2 #(.DEPTH(DEPTH), .entry_t(entry_t)) u_alu_q (
    .clk_n    (clk_n),
    .rst_n    (rst_n),
    .push     (alu_push),
    .push_dat (alu_in),
    .pop      (alu_pop),
    .head     (alu_head),
    .empty    (alu_empty),
    .ready    (alu_rdy)
  );

  wb_fifo2 #(.DEPTH(DEPTH), .entry_t(entry_t)) u_mem_q (
    .clk_n    (clk_n),
    .rst_n    (rst_n),
    .push     (mem_push),
    .push_dat (mem_in),
    .pop      (mem_pop),
    .head     (mem_head),
    .empty    (mem_empty),
    .ready    (mem_rdy)
  );

  // Only queue heads compete; the fresh input is never forwarded straight out.
  always_comb begin
    conflict  = ~alu_empty & ~mem_empty;
    grant     = ~alu_empty | ~mem_empty;
    grant_src = ALU;
    if (conflict) begin
      grant_src = ~last_grant;
    end else if (alu_empty) begin
      grant_src = MEM;
    end
    alu_pop = grant & (grant_src == ALU);
    mem_pop = grant & (grant_src == MEM);
    win     = (grant_src == ALU) ? alu_head : mem_head;
  end

  // rd==0 entries are drained silently: Wen stays low and Rd/BusW keep their
  // previous contents so downstream forwarding compares stay stable.
  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      wen_q      <= 1'b0;
      rd_q       <= '0;
      busw_q     <= '0;
      last_grant <= MEM;
    end else begin
      wen_q <= grant & (win.rd != '0);
      if (grant && (win.rd != '0)) begin
        rd_q   <= win.rd;
        busw_q <= win.data;
      end
      // Uncontested grants leave the round-robin pointer alone.
      if (conflict) begin
        last_grant <= grant_src;
      end
    end
  end

  assign bus.alu_ready = alu_rdy;
  assign bus.mem_ready = mem_rdy;
  assign bus.Wen       = wen_q;
  assign bus.Rd        = rd_q;
  assign bus.BusW      = busw_q;
  assign bus.fwd_a     = wen_q & (rd_q == bus.Rs1) & (bus.Rs1 != '0);
  assign bus.fwd_b     = wen_q & (rd_q == bus.Rs2) & (bus.Rs2 != '0);
  assign bus.idle      = alu_empty & mem_empty & ~wen_q;

endmodule
